axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI4 read master port between NREQ read requesters: instruction fetch (req 0) and load unit (req 1).
//  Round-robin grant. One outstanding transaction at a time; no AXI IDs.
//  Sits between the fetch/LSU AXI read masters and the memory interconnect.
//  Checks burst length against rlast and flags slave error responses.
// PARAMETERS
//  ADDR_WIDTH      `DATA_ADDR_WIDTH   address width
//  DATA_WIDTH      `FETCH_DATA_WIDTH  read data width
//  NREQ            2                  number of requesters (>=2)
//  TIMEOUT_CYCLES  1024               watchdog limit; used only with AXI_RD_ARB_TIMEOUT_EN
// PORTS
//  clk                                   in   1               clock
//  rst_n                                 in   1               async active-low reset
//  s_axi_araddr                          in   NREQ*ADDR_WIDTH requester AR address, packed [NREQ-1:0]
//  s_axi_arlen/arsize/arburst/arcache/arprot
//                                        in   NREQ*{8,3,2,4,3} requester AR attributes
//  s_axi_arvalid                         in   NREQ            requester AR valid
//  s_axi_arready                         out  NREQ            requester AR ready
//  s_axi_rdata                           out  DATA_WIDTH      broadcast read data
//  s_axi_rresp                           out  2               broadcast response
//  s_axi_rlast                           out  1               broadcast last beat
//  s_axi_rvalid                          out  NREQ            per-requester R valid
//  s_axi_rready                          in   NREQ            per-requester R ready
//  m_axi_araddr/arlen/arsize/arburst/arcache/arprot/arqos/arregion
//                                        out  AXI4 widths     master AR fields
//  m_axi_arvalid / m_axi_arready         out / in  1          master AR handshake
//  m_axi_rdata/rresp/rlast               in   DATA_WIDTH/2/1  master R payload
//  m_axi_rvalid / m_axi_rready           in / out  1          master R handshake
//  co_busy                               out  1               transaction in flight
//  co_grant_id                           out  $clog2(NREQ)    owner of the current or last transaction
//  co_error                              out  1               one-cycle error pulse
//  co_error_code                         out  3               error cause; valid while co_error=1
// BEHAVIOUR
//  Reset values: all valid/ready outputs 0, co_* 0, m_axi_* 0, state IDLE, round-robin pointer = 0, beat counter 0.
//  States:
//   - IDLE: if any s_arvalid, grant the first requester at or after the pointer.
//     In the same cycle, drive s_arready[g]=1, latch that requester's AR fields into registers, and move to ADDR.
//   - ADDR: m_axi_arvalid=1, driven from the latched registers and held stable.
//     On m_arvalid&m_arready, load beat_cnt=0 and move to DATA.
//   - DATA: m_axi_rready = s_axi_rready[g]; s_axi_rvalid[g] = m_axi_rvalid; all other s_rvalid stay 0.
//     Each accepted beat increments beat_cnt.
//     On the accepted beat with rlast: move to IDLE and set pointer = (g+1) mod NREQ.
//  Latency: requester arvalid in cycle N -> m_axi_arvalid in cycle N+1.
//    Minimum one IDLE cycle between transactions.
//  Fixed outputs: m_axi_arqos = 0, m_axi_arregion = 0.
//    m_axi_araddr is 0 outside ADDR.
//  Non-granted requesters: arready and rvalid stay 0; their AR fields are ignored until granted.
//  Both requesters held valid: grants alternate 0,1,0,1.
//  Error codes (co_error pulses on the offending accepted beat; the beat is still forwarded):
//   - 3'b001: rresp = SLVERR
//   - 3'b010: rresp = DECERR
//   - 3'b011: rlast on beat != latched arlen, or no rlast on beat == arlen
//  After a length error the transaction still ends only on rlast.
//  Reset mid-transaction: immediate return to IDLE; outstanding beats are not accepted.
//    The interconnect is reset by the same rst_n.
//  co_busy = (state != IDLE). co_grant_id updates at grant.
// CONFIGURATION
//  AXI_RD_ARB_TIMEOUT_EN defined:
//   - A counter runs in ADDR/DATA and clears on any AR or R handshake.
//   - Reaching TIMEOUT_CYCLES pulses co_error with code 3'b100 once per stall and re-arms.
//   - The transaction is not aborted.
//  AXI_RD_ARB_TIMEOUT_EN undefined: no counter; code 3'b100 never produced; TIMEOUT_CYCLES unused.
// STRUCTURE
//  defs.svh additions:
//   - arb_state_t enum {IDLE, ADDR, DATA}
//   - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
//   - ARB_ERR_* code localparams
//   - ar_req_t struct {addr, len, size, burst, cache, prot}
//  Sub-module rr_arbiter_n:
//   - combinational round-robin pick: req vector + pointer -> one-hot grant + index
//   - the pointer register stays in axi_rd_arbiter
// TESTING
//  - Reset asserted mid-DATA -> state IDLE, m_rready=0 and all s_rvalid=0 asynchronously; next request is granted normally.
//  - Req0 only, araddr=0x100, arlen=3 -> m_arvalid next cycle with addr 0x100; 4 beats reach req0 only; co_error never set.
//  - Req0 and req1 both held valid for 4 transactions -> grant order 0,1,0,1; each m_araddr matches its owner's address.
//  - Req1 has rready low for 5 cycles during a burst -> m_rready low for those cycles; no beat lost or duplicated.
//  - arlen=3, slave asserts rlast on beat 1 -> co_error pulse with code 3'b011; state returns to IDLE; the next grant goes to the other requester.
//  - Slave returns rresp=2'b10 on beat 2 -> co_error pulse with code 3'b001 on that beat.
//    With AXI_RD_ARB_TIMEOUT_EN: arready held low for 1024 cycles -> co_error pulse with code 3'b100.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter.
// Default widths come from DATA_ADDR_WIDTH / FETCH_DATA_WIDTH when the build does not set them.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 32
`endif
`ifndef FETCH_DATA_WIDTH
`define FETCH_DATA_WIDTH 64
`endif

package axi_rd_arbiter_pkg;

  localparam int ARB_ADDR_W = `DATA_ADDR_WIDTH;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_ADDR = 2'd1;
  localparam arb_state_t ARB_DATA = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] ARB_ERR_NONE    = 3'b000;
  localparam logic [2:0] ARB_ERR_SLVERR  = 3'b001;
  localparam logic [2:0] ARB_ERR_DECERR  = 3'b010;
  localparam logic [2:0] ARB_ERR_LEN     = 3'b011;
  localparam logic [2:0] ARB_ERR_TIMEOUT = 3'b100;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } ar_req_t;

  // Slave error responses take precedence over a burst-length mismatch on the same beat.
  function automatic logic [2:0] beat_err_code(input logic [1:0] resp,
                                               input logic       rlast,
                                               input logic       last_expected);
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:
        return (rlast != last_expected) ? ARB_ERR_LEN : ARB_ERR_NONE;
      AXI_RESP_SLVERR: return ARB_ERR_SLVERR;
      default:         return ARB_ERR_DECERR;
    endcase
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr wins.
// The pointer register itself lives in the parent.
module rr_arbiter_n #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between NREQ requesters, one transaction at a time, round-robin.
// Optional AR/R stall watchdog enabled with AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = `DATA_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `FETCH_DATA_WIDTH,
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [NREQ*8-1:0]          s_axi_arlen,
  input  logic [NREQ*3-1:0]          s_axi_arsize,
  input  logic [NREQ*2-1:0]          s_axi_arburst,
  input  logic [NREQ*4-1:0]          s_axi_arcache,
  input  logic [NREQ*3-1:0]          s_axi_arprot,
  input  logic [NREQ-1:0]            s_axi_arvalid,
  output logic [NREQ-1:0]            s_axi_arready,
  output logic [DATA_WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic [NREQ-1:0]            s_axi_rvalid,
  input  logic [NREQ-1:0]            s_axi_rready,
  output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic [3:0]                 m_axi_arqos,
  output logic [3:0]                 m_axi_arregion,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic                       co_busy,
  output logic [IDX_W-1:0]           co_grant_id,
  output logic                       co_error,
  output logic [2:0]                 co_error_code
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [7:0]       beat_cnt;
  ar_req_t          ar_q;
  ar_req_t          cand_req [NREQ];

  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             ar_hs;
  logic             beat;
  logic [2:0]       beat_code;
  logic             to_hit;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cand_req[i] = '{addr:  ARB_ADDR_W'(s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
                           len:   s_axi_arlen[i*8 +: 8],
                           size:  s_axi_arsize[i*3 +: 3],
                           burst: s_axi_arburst[i*2 +: 2],
                           cache: s_axi_arcache[i*4 +: 4],
                           prot:  s_axi_arprot[i*3 +: 3]};
  end

  rr_arbiter_n #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req   (s_axi_arvalid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign s_axi_arready = (state == ARB_IDLE) ? pick_grant : '0;

  assign m_axi_arvalid  = (state == ARB_ADDR);
  assign m_axi_araddr   = m_axi_arvalid ? ADDR_WIDTH'(ar_q.addr) : '0;
  assign m_axi_arlen    = ar_q.len;
  assign m_axi_arsize   = ar_q.size;
  assign m_axi_arburst  = ar_q.burst;
  assign m_axi_arcache  = ar_q.cache;
  assign m_axi_arprot   = ar_q.prot;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;

  // R channel is routed only to the owner; payload is broadcast and qualified by rvalid.
  assign m_axi_rready = (state == ARB_DATA) && s_axi_rready[co_grant_id];
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;

  always_comb begin
    s_axi_rvalid = '0;
    if (state == ARB_DATA) s_axi_rvalid[co_grant_id] = m_axi_rvalid;
  end

  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign beat      = (state == ARB_DATA) && m_axi_rvalid && m_axi_rready;
  assign beat_code = beat_err_code(m_axi_rresp, m_axi_rlast, beat_cnt == ar_q.len);

  assign co_busy       = (state != ARB_IDLE);
  assign co_error      = to_hit || (beat && (beat_code != ARB_ERR_NONE));
  assign co_error_code = to_hit ? ARB_ERR_TIMEOUT : (co_error ? beat_code : ARB_ERR_NONE);

  // NOTE: sequential state uses non-blocking assignments only; the latched AR payload
  // is reset too because the m_axi_* attribute outputs must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      ar_q        <= '0;
      co_grant_id <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            ar_q        <= cand_req[pick_idx];
            co_grant_id <= pick_idx;
            state       <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (ar_hs) begin
            beat_cnt <= '0;
            state    <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            // A length error never ends the burst early; only rlast does.
            if (m_axi_rlast) begin
              state  <= ARB_IDLE;
              rr_ptr <= (co_grant_id == IDX_W'(NREQ - 1)) ? '0 : co_grant_id + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef AXI_RD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state != ARB_IDLE) && !ar_hs && !beat &&
                  (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Clearing on the hit re-arms the watchdog for the next stall window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if ((state == ARB_IDLE) || ar_hs || beat || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule
